// File: rtl/flush_controller_if.sv
// Handshake bundle between retire/hazard/fetch and the flush controller.
// Signal prefixes are from the controller's point of view.
interface flush_controller_if #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 4
);
    logic              i_mispredict_valid;
    logic [ADDR_W-1:0] i_mispredict_pc;
    logic [IDX_W-1:0]  i_mispredict_idx;
    logic [IDX_W-1:0]  i_rob_tail;
    logic              i_data_busy;
    logic              i_write_busy;
    logic              o_flushing;
    logic              o_overwrite_pc;
    logic [ADDR_W-1:0] o_new_pc;
    logic              o_rob_clear_valid;
    logic [IDX_W-1:0]  o_rob_clear_idx;
    logic              o_flush_done;

    modport master (
        output i_mispredict_valid, i_mispredict_pc, i_mispredict_idx, i_rob_tail,
               i_data_busy, i_write_busy,
        input  o_flushing, o_overwrite_pc, o_new_pc, o_rob_clear_valid,
               o_rob_clear_idx, o_flush_done
    );

    modport slave (
        input  i_mispredict_valid, i_mispredict_pc, i_mispredict_idx, i_rob_tail,
               i_data_busy, i_write_busy,
        output o_flushing, o_overwrite_pc, o_new_pc, o_rob_clear_valid,
               o_rob_clear_idx, o_flush_done
    );
endinterface

// File: rtl/flush_controller.sv
// Mispredict recovery sequencer: drain memory activity, invalidate younger ROB
// entries one per cycle, then redirect fetch. All outputs are registered.
module flush_controller #(
    parameter int ROB_SIZE = 16,
    parameter int IDX_W    = $clog2(ROB_SIZE),
    parameter int ADDR_W   = 32
) (
    input logic               clk,
    input logic               reset,
    flush_controller_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_WALK,
        ST_REDIRECT,
        ST_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_tgt;
    logic [ADDR_W-1:0] w_tgt_nxt;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  w_ptr_nxt;
    logic [IDX_W-1:0]  r_end;
    logic [IDX_W-1:0]  w_end_nxt;

    logic              r_flushing;
    logic              r_overwrite_pc;
    logic [ADDR_W-1:0] r_new_pc;
    logic              r_rob_clear_valid;
    logic [IDX_W-1:0]  r_rob_clear_idx;
    logic              r_flush_done;

    // r_ptr is the entry cleared in the current WALK cycle; ROB_SIZE is a
    // power of two so index arithmetic wraps for free.
    always_comb begin
        w_state_nxt = r_state;
        w_tgt_nxt   = r_tgt;
        w_ptr_nxt   = r_ptr;
        w_end_nxt   = r_end;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_mispredict_valid) begin
                    w_tgt_nxt   = bus.i_mispredict_pc;
                    w_ptr_nxt   = bus.i_mispredict_idx + IDX_W'(1);
                    w_end_nxt   = bus.i_rob_tail;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!(bus.i_data_busy || bus.i_write_busy)) begin
                    w_state_nxt = (r_ptr != r_end) ? ST_WALK : ST_REDIRECT;
                end
            end
            ST_WALK: begin
                w_ptr_nxt = r_ptr + IDX_W'(1);
                if (w_ptr_nxt == r_end) begin
                    w_state_nxt = ST_REDIRECT;
                end
            end
            ST_REDIRECT: w_state_nxt = ST_DONE;
            ST_DONE:     w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear glitch-free from flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state           <= ST_IDLE;
            r_tgt             <= '0;
            r_ptr             <= '0;
            r_end             <= '0;
            r_flushing        <= 1'b0;
            r_overwrite_pc    <= 1'b0;
            r_new_pc          <= '0;
            r_rob_clear_valid <= 1'b0;
            r_rob_clear_idx   <= '0;
            r_flush_done      <= 1'b0;
        end else begin
            r_state           <= w_state_nxt;
            r_tgt             <= w_tgt_nxt;
            r_ptr             <= w_ptr_nxt;
            r_end             <= w_end_nxt;
            r_flushing        <= (w_state_nxt == ST_DRAIN) || (w_state_nxt == ST_WALK) ||
                                 (w_state_nxt == ST_REDIRECT);
            r_overwrite_pc    <= (w_state_nxt == ST_REDIRECT);
            r_new_pc          <= (w_state_nxt == ST_REDIRECT) ? w_tgt_nxt : '0;
            r_rob_clear_valid <= (w_state_nxt == ST_WALK);
            r_rob_clear_idx   <= (w_state_nxt == ST_WALK) ? w_ptr_nxt : '0;
            r_flush_done      <= (w_state_nxt == ST_DONE);
        end
    end

    assign bus.o_flushing        = r_flushing;
    assign bus.o_overwrite_pc    = r_overwrite_pc;
    assign bus.o_new_pc          = r_new_pc;
    assign bus.o_rob_clear_valid = r_rob_clear_valid;
    assign bus.o_rob_clear_idx   = r_rob_clear_idx;
    assign bus.o_flush_done      = r_flush_done;
endmodule

// File: tb/tb_flush_controller.sv
// Self-checking bench for flush_controller: directed and random flushes
// checked cycle by cycle against an arithmetic timeline model.
module tb_flush_controller;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    flush_controller_if #(.ADDR_W(32), .IDX_W(4)) bus ();

    flush_controller #(.ROB_SIZE(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        bus.i_mispredict_valid = 1'b0;
        bus.i_mispredict_pc    = '0;
        bus.i_mispredict_idx   = '0;
        bus.i_rob_tail         = '0;
        bus.i_data_busy        = 1'b0;
        bus.i_write_busy       = 1'b0;
    endtask

    // Timeline model, sample s taken at the negedge after the s-th posedge from
    // the mispredict: DRAIN for 1..D+1, N clears, one redirect, one done.
    task automatic run_flush(input string name, input int idx, input int tail,
                             input logic [31:0] pc, input int d, input int w,
                             input bit glitch);
        int n;
        int dt;
        int e;
        logic exp_flush, exp_clr, exp_ov, exp_done;
        logic [3:0] exp_idx;
        n  = (tail - idx - 1 + 32) % 16;
        dt = d + w;
        @(negedge clk);
        bus.i_mispredict_valid = 1'b1;
        bus.i_mispredict_pc    = pc;
        bus.i_mispredict_idx   = 4'(idx);
        bus.i_rob_tail         = 4'(tail);
        bus.i_data_busy        = 1'b0;
        bus.i_write_busy       = 1'b0;
        for (int s = 1; s <= dt + n + 5; s++) begin
            @(negedge clk);
            exp_flush = (s <= dt + n + 2);
            exp_clr   = (s >= dt + 2) && (s <= dt + n + 1);
            exp_idx   = 4'(idx + 1 + (s - dt - 2));
            exp_ov    = (s == dt + n + 2);
            exp_done  = (s == dt + n + 3);
            n_checks++;
            if (bus.o_flushing !== exp_flush) begin
                n_fail++;
                $display("FAIL %s flushing s=%0d got %b exp %b", name, s, bus.o_flushing, exp_flush);
            end
            n_checks++;
            if (bus.o_rob_clear_valid !== exp_clr) begin
                n_fail++;
                $display("FAIL %s clear_valid s=%0d got %b exp %b", name, s, bus.o_rob_clear_valid, exp_clr);
            end
            if (exp_clr) begin
                n_checks++;
                if (bus.o_rob_clear_idx !== exp_idx) begin
                    n_fail++;
                    $display("FAIL %s clear_idx s=%0d got %0d exp %0d", name, s, bus.o_rob_clear_idx, exp_idx);
                end
            end
            n_checks++;
            if (bus.o_overwrite_pc !== exp_ov) begin
                n_fail++;
                $display("FAIL %s overwrite_pc s=%0d got %b exp %b", name, s, bus.o_overwrite_pc, exp_ov);
            end
            if (exp_ov) begin
                n_checks++;
                if (bus.o_new_pc !== pc) begin
                    n_fail++;
                    $display("FAIL %s new_pc got %h exp %h", name, bus.o_new_pc, pc);
                end
            end
            n_checks++;
            if (bus.o_flush_done !== exp_done) begin
                n_fail++;
                $display("FAIL %s flush_done s=%0d got %b exp %b", name, s, bus.o_flush_done, exp_done);
            end
            // Inputs for the next edge: busy windows, late tail noise, optional stray mispredict
            e = s + 1;
            bus.i_data_busy        = (e >= 2) && (e < 2 + d);
            bus.i_write_busy       = (e >= 2 + d) && (e < 2 + dt);
            bus.i_rob_tail         = 4'($urandom_range(0, 15));
            bus.i_mispredict_valid = glitch && (e == dt + 3);
            bus.i_mispredict_pc    = $urandom;
            bus.i_mispredict_idx   = 4'($urandom_range(0, 15));
            if (e > dt + n + 3) bus.i_mispredict_valid = 1'b0;
        end
        drive_idle();
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({bus.o_flushing, bus.o_overwrite_pc, bus.o_rob_clear_valid, bus.o_flush_done} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b exp 0000",
                     {bus.o_flushing, bus.o_overwrite_pc, bus.o_rob_clear_valid, bus.o_flush_done});
        end
        n_checks++;
        if (bus.o_new_pc !== 32'h0 || bus.o_rob_clear_idx !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_data new_pc %h idx %0d exp 0", bus.o_new_pc, bus.o_rob_clear_idx);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        run_flush("basic", 3, 7, 32'h0000_1040, 0, 0, 1'b0);
    endtask

    task automatic test_wrap();
        run_flush("wrap", 14, 2, 32'hCAFE_0000, 0, 0, 1'b0);
    endtask

    task automatic test_empty();
        run_flush("empty", 5, 6, 32'h0000_2000, 0, 0, 1'b0);
    endtask

    task automatic test_drain();
        run_flush("drain", 1, 4, 32'h0000_3000, 4, 2, 1'b0);
    endtask

    task automatic test_full_rob();
        run_flush("full_rob", 9, 9, 32'h8000_0004, 0, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_flush("b2b_a", 0, 3, 32'h1111_0000, 1, 0, 1'b0);
        run_flush("b2b_b", 7, 7, 32'h2222_0000, 0, 1, 1'b1);
    endtask

    task automatic test_reset_mid_walk();
        @(negedge clk);
        bus.i_mispredict_valid = 1'b1;
        bus.i_mispredict_pc    = 32'h0000_5000;
        bus.i_mispredict_idx   = 4'd2;
        bus.i_rob_tail         = 4'd10;
        @(negedge clk);
        bus.i_mispredict_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.o_rob_clear_valid !== 1'b1 || bus.o_rob_clear_idx !== 4'd5) begin
            n_fail++;
            $display("FAIL rst_walk third_clear got v=%b idx=%0d exp v=1 idx=5",
                     bus.o_rob_clear_valid, bus.o_rob_clear_idx);
        end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.o_flushing, bus.o_overwrite_pc, bus.o_rob_clear_valid, bus.o_flush_done} !== 4'b0 ||
            bus.o_rob_clear_idx !== 4'd0 || bus.o_new_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_walk async_clear got flags %b idx %0d pc %h exp 0",
                     {bus.o_flushing, bus.o_overwrite_pc, bus.o_rob_clear_valid, bus.o_flush_done},
                     bus.o_rob_clear_idx, bus.o_new_pc);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int s = 0; s < 12; s++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.o_flushing, bus.o_overwrite_pc, bus.o_rob_clear_valid, bus.o_flush_done} !== 4'b0) begin
                n_fail++;
                $display("FAIL rst_walk post_release s=%0d got %b exp 0000", s,
                         {bus.o_flushing, bus.o_overwrite_pc, bus.o_rob_clear_valid, bus.o_flush_done});
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            run_flush("random", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), $urandom,
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        drive_idle();
        test_reset();
        test_basic();
        test_wrap();
        test_empty();
        test_drain();
        test_full_rob();
        test_back_to_back();
        test_reset_mid_walk();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
